// File: rtl/masked_and_chain_sequencer.sv
// Sequences one registered DOM-style 2-share AND gadget over N_IN operands,
// consuming one fresh random word per gadget step over a valid/ready port.
module masked_and_chain_sequencer #(
  parameter int N_IN  = 3,
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*WIDTH-1:0]   in_s0,
  input  logic [N_IN*WIDTH-1:0]   in_s1,
  input  logic                    rnd_valid,
  output logic                    rnd_ready,
  input  logic [WIDTH-1:0]        rnd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_s0,
  output logic [WIDTH-1:0]        out_s1,
  output logic                    busy,
  output logic [1:0]              state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; ready never depends on the matching valid, and out_s0/out_s1
  // stay stable while out_valid is high and out_ready is low.

  localparam int SW = $clog2(N_IN);
  localparam logic [SW-1:0] LAST_STEP = SW'(N_IN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [N_IN*WIDTH-1:0] ops_s0, ops_s1;
  logic [WIDTH-1:0]      acc0, acc1;
  logic [WIDTH-1:0]      t0, t1, c0, c1;
  logic [WIDTH-1:0]      y0, y1;
  logic [SW-1:0]         step;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    rnd_ready = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = MUL;
      end
      MUL: begin
        rnd_ready = 1'b1;
        if (rnd_valid) state_nxt = COMP;
      end
      COMP: begin
        if (step == LAST_STEP) state_nxt = DONE;
        else                   state_nxt = MUL;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand selected by the step counter for the current gadget invocation.
  always_comb begin
    y0 = '0;
    y1 = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (step == SW'(i)) begin
        y0 = ops_s0[i*WIDTH +: WIDTH];
        y1 = ops_s1[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_s0 <= '0;
      ops_s1 <= '0;
      acc0   <= '0;
      acc1   <= '0;
      t0     <= '0;
      t1     <= '0;
      c0     <= '0;
      c1     <= '0;
      step   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ops_s0 <= in_s0;
            ops_s1 <= in_s1;
            acc0   <= in_s0[WIDTH-1:0];
            acc1   <= in_s1[WIDTH-1:0];
            step   <= SW'(1);
          end
        end
        MUL: begin
          // Cross-terms are blinded by z and registered before recombination.
          if (rnd_valid) begin
            t0 <= acc0 & y0;
            t1 <= acc1 & y1;
            c0 <= (acc0 & y1) ^ rnd;
            c1 <= (acc1 & y0) ^ rnd;
          end
        end
        COMP: begin
          acc0 <= t0 ^ c0;
          acc1 <= t1 ^ c1;
          if (step != LAST_STEP) step <= step + SW'(1);
        end
        DONE: begin
          // Scrub every share-bearing register once the result is taken.
          if (out_ready) begin
            ops_s0 <= '0;
            ops_s1 <= '0;
            acc0   <= '0;
            acc1   <= '0;
            t0     <= '0;
            t1     <= '0;
            c0     <= '0;
            c1     <= '0;
            step   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_s0    = (state == DONE) ? acc0 : '0;
  assign out_s1    = (state == DONE) ? acc1 : '0;
  assign state_dbg = state;

endmodule

// File: tb/tb_masked_and_chain_sequencer.sv
// Bench for masked_and_chain_sequencer: a 3x1 instance for exhaustive, stall,
// hold, randomness and reset scenarios, and a 5x8 instance for wide vectors.
module tb_masked_and_chain_sequencer;

  logic clk;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  // instance a: N_IN=3, WIDTH=1
  logic       rst_a, a_in_valid, a_in_ready, a_rnd_valid, a_rnd_ready;
  logic [2:0] a_in_s0, a_in_s1;
  logic [0:0] a_rnd, a_out_s0, a_out_s1;
  logic       a_out_valid, a_out_ready, a_busy;
  logic [1:0] a_state;

  // instance b: N_IN=5, WIDTH=8
  logic        rst_b, b_in_valid, b_in_ready, b_rnd_valid, b_rnd_ready;
  logic [39:0] b_in_s0, b_in_s1;
  logic [7:0]  b_rnd, b_out_s0, b_out_s1;
  logic        b_out_valid, b_out_ready, b_busy;
  logic [1:0]  b_state;

  masked_and_chain_sequencer #(.N_IN(3), .WIDTH(1)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_s0(a_in_s0), .in_s1(a_in_s1), .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready),
    .rnd(a_rnd), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_s0(a_out_s0), .out_s1(a_out_s1), .busy(a_busy), .state_dbg(a_state)
  );

  masked_and_chain_sequencer #(.N_IN(5), .WIDTH(8)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_s0(b_in_s0), .in_s1(b_in_s1), .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready),
    .rnd(b_rnd), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_s0(b_out_s0), .out_s1(b_out_s1), .busy(b_busy), .state_dbg(b_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    a_in_valid = 0; a_in_s0 = '0; a_in_s1 = '0; a_rnd_valid = 1; a_rnd = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_s0 = '0; b_in_s1 = '0; b_rnd_valid = 1; b_rnd = '0; b_out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    checks++;
    if ({a_in_ready, a_rnd_ready, a_out_valid, a_busy, a_out_s0, a_out_s1, a_state} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_a: got %b expected %b",
               {a_in_ready, a_rnd_ready, a_out_valid, a_busy, a_out_s0, a_out_s1, a_state}, 8'b1000_0000);
    end
    checks++;
    if ({b_in_ready, b_rnd_ready, b_out_valid, b_busy, b_out_s0, b_out_s1, b_state} !== {4'b1000, 16'h0, 2'd0}) begin
      failures++;
      $display("FAIL reset_b: got %h expected %h",
               {b_in_ready, b_rnd_ready, b_out_valid, b_busy, b_out_s0, b_out_s1, b_state}, {4'b1000, 16'h0, 2'd0});
    end
  endtask

  // One operation on instance a. Called with the DUT in IDLE, #1 after an edge.
  task automatic a_op(input logic [2:0] s0, input logic [2:0] s1, input int stall,
                      input int hold, input bit fixed_z, input logic [1:0] zseq,
                      input string tag, output logic out0);
    int cyc, hs, stall_left;
    logic [7:0] exp, got;
    logic h0, h1;
    exp = {7'd0, (s0[0] ^ s1[0]) & (s0[1] ^ s1[1]) & (s0[2] ^ s1[2])};
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_in_ready: got %b expected 1", tag, a_in_ready);
    end
    a_in_s0 = s0; a_in_s1 = s1; a_in_valid = 1'b1; a_out_ready = 1'b0;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_s0 = 3'($urandom); a_in_s1 = 3'($urandom);
    cyc = 0; hs = 0; stall_left = stall;
    while (a_out_valid !== 1'b1 && cyc < 40) begin
      if (a_rnd_ready === 1'b1 && stall_left > 0) begin
        a_rnd_valid = 1'b0;
        stall_left--;
        checks++;
        if (a_state !== 2'd1) begin
          failures++;
          $display("FAIL %s_stall_state: got %0d expected 1", tag, a_state);
        end
      end else begin
        a_rnd_valid = 1'b1;
        a_rnd = fixed_z ? zseq[hs[0]] : 1'($urandom);
      end
      a_in_valid = 1'($urandom);
      if (a_rnd_valid && a_rnd_ready) hs++;
      @(posedge clk); #1;
      cyc++;
    end
    a_in_valid = 1'b0;
    checks++;
    if (cyc !== 4 + stall) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected %0d", tag, cyc, 4 + stall);
    end
    checks++;
    if (hs !== 2) begin
      failures++;
      $display("FAIL %s_rnd_handshakes: got %0d expected 2", tag, hs);
    end
    got = exp_q.pop_front();
    checks++;
    if ((a_out_s0 ^ a_out_s1) !== got[0]) begin
      failures++;
      $display("FAIL %s_product: got %b expected %b", tag, a_out_s0 ^ a_out_s1, got[0]);
    end
    h0 = a_out_s0; h1 = a_out_s1; out0 = a_out_s0;
    for (int k = 0; k < hold; k++) begin
      a_in_valid = 1'($urandom);
      a_rnd_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({a_out_valid, a_out_s0, a_out_s1, a_in_ready, a_busy, a_rnd_ready} !== {1'b1, h0, h1, 1'b0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL %s_done_hold: got %b expected %b", tag,
                 {a_out_valid, a_out_s0, a_out_s1, a_in_ready, a_busy, a_rnd_ready}, {1'b1, h0, h1, 1'b0, 1'b1, 1'b0});
      end
    end
    // in_valid is high on the edge that leaves DONE and must not be taken.
    a_out_ready = 1'b1; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0; a_in_valid = 1'b0;
    checks++;
    if ({a_state, a_out_valid, a_busy, a_in_ready, a_out_s0, a_out_s1} !== 7'b00_0_0_1_0_0) begin
      failures++;
      $display("FAIL %s_leave_done: got %b expected %b", tag,
               {a_state, a_out_valid, a_busy, a_in_ready, a_out_s0, a_out_s1}, 7'b00_0_0_1_0_0);
    end
  endtask

  task automatic b_op(input logic [39:0] s0, input logic [39:0] s1, input string tag);
    int cyc, hs;
    logic [7:0] exp, got;
    exp = 8'hFF;
    for (int i = 0; i < 5; i++) exp = exp & (s0[i*8 +: 8] ^ s1[i*8 +: 8]);
    b_in_s0 = s0; b_in_s1 = s1; b_in_valid = 1'b1; b_out_ready = 1'b0;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    cyc = 0; hs = 0;
    while (b_out_valid !== 1'b1 && cyc < 60) begin
      b_rnd_valid = 1'b1;
      b_rnd = 8'($urandom);
      if (b_rnd_valid && b_rnd_ready) hs++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 8) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected 8", tag, cyc);
    end
    checks++;
    if (hs !== 4) begin
      failures++;
      $display("FAIL %s_rnd_handshakes: got %0d expected 4", tag, hs);
    end
    got = exp_q.pop_front();
    checks++;
    if ((b_out_s0 ^ b_out_s1) !== got) begin
      failures++;
      $display("FAIL %s_product: got %h expected %h", tag, b_out_s0 ^ b_out_s1, got);
    end
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    checks++;
    if ({b_state, b_out_valid, b_in_ready} !== 4'b00_0_1) begin
      failures++;
      $display("FAIL %s_leave_done: got %b expected 0001", tag, {b_state, b_out_valid, b_in_ready});
    end
  endtask

  task automatic test_exhaustive();
    logic o;
    for (int v = 0; v < 64; v++) begin
      logic [5:0] vv;
      vv = 6'(v);
      a_op(vv[2:0], vv[5:3], 0, 0, 1'b0, 2'b00, "exh", o);
    end
  endtask

  task automatic test_randomness();
    logic o1, o2;
    // a=(1,0), b=(0,1), c=(0,1): all operands unmask to 1
    a_op(3'b001, 3'b110, 0, 0, 1'b1, 2'b00, "z_run0", o1);
    a_op(3'b001, 3'b110, 0, 0, 1'b1, 2'b10, "z_run1", o2);
    checks++;
    if (o1 === o2) begin
      failures++;
      $display("FAIL z_reaches_share: got out_s0 %b and %b expected them to differ", o1, o2);
    end
  endtask

  task automatic test_rnd_stall();
    logic o;
    a_op(3'b101, 3'b010, 5, 0, 1'b0, 2'b00, "stall_ones", o);
    a_op(3'($urandom), 3'($urandom), 5, 0, 1'b0, 2'b00, "stall_rand", o);
  endtask

  task automatic test_out_hold();
    logic o;
    a_op(3'b011, 3'b100, 0, 10, 1'b0, 2'b00, "hold", o);
  endtask

  task automatic test_mid_reset();
    int hs;
    logic o;
    a_in_s0 = 3'b111; a_in_s1 = 3'b000; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_rnd_valid = 1'b1; a_rnd = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_state !== 2'd2) begin
      failures++;
      $display("FAIL midrst_in_comp: got %0d expected 2", a_state);
    end
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    checks++;
    if ({a_in_ready, a_out_valid, a_busy, a_state} !== 5'b100_00) begin
      failures++;
      $display("FAIL midrst_after: got %b expected 10000", {a_in_ready, a_out_valid, a_busy, a_state});
    end
    hs = 0;
    for (int k = 0; k < 5; k++) begin
      a_rnd_valid = 1'b1;
      if (a_rnd_valid && a_rnd_ready) hs++;
      @(posedge clk); #1;
    end
    checks++;
    if (hs !== 0) begin
      failures++;
      $display("FAIL midrst_no_rnd: got %0d expected 0", hs);
    end
    a_op(3'b110, 3'b001, 0, 0, 1'b0, 2'b00, "post_rst", o);
  endtask

  task automatic test_wide();
    for (int n = 0; n < 20; n++) begin
      logic [39:0] s0, s1, p;
      s0 = {8'($urandom), $urandom};
      // bias toward nonzero products by unmasking most lanes to 1
      p  = (n % 2 == 0) ? {8'($urandom), $urandom} : ~{8'($urandom), $urandom} | {8'($urandom), $urandom};
      s1 = s0 ^ p;
      b_op(s0, s1, "wide");
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_randomness();
    test_rnd_stall();
    test_out_hold();
    test_mid_reset();
    test_wide();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
